frame_pixel_streamer: RTL and testbench

- Raster-order pixel source that reads a stored frame out of a synchronous-read frame RAM and drives it as a 24-bit valid/ready pixel stream.
- It is the producer end of the pixel-stream interface consumed by ale_top and the downstream dehaze stages.
- It replaces bench-side BMP feeding with synthesizable frame playback, including downstream stall support and frame markers.

---
 rtl/frame_pixel_streamer.sv | 152 +++++++++++++++
 tb/tb_frame_pixel_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_streamer.sv
// Raster-order frame playback: reads a stored frame from a synchronous-read RAM
// and drives it as a valid/ready pixel stream with sol/eol/eof markers.
module frame_pixel_streamer #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 18,
  parameter int PIX_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [PIX_W-1:0]  out_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sol,
  output logic              out_eol,
  output logic              out_eof,
  output logic              frame_done
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int EW = PIX_W + 3;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_p0;
  logic [XW-1:0]     x_p0;
  logic [YW-1:0]     y_p0;
  logic              vld_p1;
  logic [2:0]        flags_p1;
  logic [EW-1:0]     fifo0;
  logic [EW-1:0]     fifo1;
  logic [EW-1:0]     entry_new;
  logic [1:0]        count;
  logic [2:0]        occ;
  logic              pop;
  logic              push;
  logic              last_x;
  logic              last_pix;

  assign pop       = out_valid & out_ready;
  assign push      = vld_p1;
  assign last_x    = (x_p0 == XW'(WIDTH - 1));
  assign last_pix  = last_x && (y_p0 == YW'(HEIGHT - 1));
  assign entry_new = {flags_p1, mem_rd_data};

  // Occupancy counts the beat leaving this cycle, so reads continue at full rate.
  always_comb begin
    occ       = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
    mem_rd_en = (state == STREAM) && (occ < 3'd2);
  end

  assign mem_addr  = addr_p0;
  assign out_valid = (count != 2'd0);
  assign out_pixel = fifo0[PIX_W-1:0];
  assign out_sol   = fifo0[PIX_W]   & out_valid;
  assign out_eol   = fifo0[PIX_W+1] & out_valid;
  assign out_eof   = fifo0[PIX_W+2] & out_valid;

  // Stage p0: address/coordinate generation and frame control
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      addr_p0    <= '0;
      x_p0       <= '0;
      y_p0       <= '0;
      vld_p1     <= 1'b0;
      flags_p1   <= '0;
    end else begin
      vld_p1     <= mem_rd_en;
      frame_done <= 1'b0;
      if (mem_rd_en)
        flags_p1 <= {last_pix, last_x, (x_p0 == '0)};
      case (state)
        IDLE: begin
          if (start) begin
            state   <= STREAM;
            busy    <= 1'b1;
            addr_p0 <= '0;
            x_p0    <= '0;
            y_p0    <= '0;
          end
        end
        STREAM: begin
          if (mem_rd_en) begin
            addr_p0 <= addr_p0 + ADDR_W'(1);
            if (last_x) begin
              x_p0 <= '0;
              y_p0 <= y_p0 + YW'(1);
            end else begin
              x_p0 <= x_p0 + XW'(1);
            end
            if (last_pix)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_eof) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: returning RAM data lands in the 2-entry output FIFO; fifo0 is the head
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo0 <= '0;
      fifo1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0)
            fifo0 <= entry_new;
          else
            fifo1 <= entry_new;
          count <= count + 2'd1;
        end
        2'b01: begin
          fifo0 <= fifo1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            fifo0 <= entry_new;
          end else begin
            fifo0 <= fifo1;
            fifo1 <= entry_new;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Bench for frame_pixel_streamer on a 4x2 frame: directed steps with randomized
// RAM contents and ready patterns, checked against a frame-level reference model.
module tb_frame_pixel_streamer;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AW = 18;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, mem_rd_en, out_valid, out_sol, out_eol, out_eof, frame_done;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rd_data = '0;
  logic [PW-1:0] out_pixel;

  always #5 clk = ~clk;

  frame_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_sol(out_sol), .out_eol(out_eol), .out_eof(out_eof), .frame_done(frame_done)
  );

  logic [PW-1:0] ram [N];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr[2:0]];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the frame is a list of N pixels in raster order.
  logic [PW-1:0]   exp_pix [N];
  int              issue_idx, beat_idx, done_cnt;
  logic            prev_stall = 1'b0;
  logic [PW+3:0]   snap;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_rd_en) begin
        chk("rd_addr", 64'(mem_addr), 64'(issue_idx));
        chk("rd_window", ((issue_idx - beat_idx - ((out_valid && out_ready) ? 1 : 0)) < 2) ? 64'd1 : 64'd0, 64'd1);
        issue_idx++;
      end
      if (out_valid && out_ready) begin
        if (beat_idx >= N) begin
          chk("extra_beat", 64'(beat_idx), 64'(N - 1));
        end else begin
          chk("beat_pix", 64'(out_pixel), 64'(exp_pix[beat_idx]));
          chk("beat_flags", 64'({out_sol, out_eol, out_eof}),
              64'({(beat_idx % W) == 0, (beat_idx % W) == W - 1, beat_idx == N - 1}));
        end
        beat_idx++;
      end
      if (prev_stall)
        chk("stall_hold", 64'({out_valid, out_sol, out_eol, out_eof, out_pixel}), 64'(snap));
      prev_stall = out_valid && !out_ready;
      snap = {out_valid, out_sol, out_eol, out_eof, out_pixel};
      if (frame_done) done_cnt++;
    end
  end

  int mode = 0;
  int cyc = 0;
  int fc, busy_cnt, first_vc;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2: out_ready = 1'b0;
      default: out_ready = ($urandom_range(2) != 0);
    endcase
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) ram[i] = PW'($urandom);
  endtask

  task automatic begin_frame();
    issue_idx = 0; beat_idx = 0; done_cnt = 0; prev_stall = 1'b0;
    for (int i = 0; i < N; i++) exp_pix[i] = ram[i];
    start = 1'b1;
    step();
    start = 1'b0;
    fc = 1; busy_cnt = 0; first_vc = -1;
    chk("first_read", 64'({mem_rd_en, mem_addr}), 64'({1'b1, AW'(0)}));
  endtask

  task automatic wait_done(input int extra_start_at);
    bit seen = 0;
    while (!seen && fc < 300) begin
      if (busy) busy_cnt++;
      if (out_valid && first_vc < 0) first_vc = fc;
      if (frame_done) begin
        seen = 1;
      end else begin
        start = (fc == extra_start_at);
        step();
        fc++;
      end
    end
    start = 1'b0;
    chk("frame_done_seen", 64'(seen), 64'd1);
  endtask

  initial begin
    mode = 2;
    for (int i = 0; i < N; i++) ram[i] = PW'(24'h010203 * i);
    rst = 1'b1;
    repeat (3) step();
    chk("reset_outputs", 64'({busy, mem_rd_en, out_valid, out_sol, out_eol, out_eof, frame_done, mem_addr, out_pixel}), 64'd0);
    rst = 1'b0;
    step();
    chk("idle_no_read", 64'({busy, mem_rd_en}), 64'd0);

    // Full-rate frame with the ramp pattern
    mode = 0; out_ready = 1'b1;
    begin_frame();
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(-1);
    chk("first_valid_latency", 64'(first_vc), 64'd3);
    chk("frame_done_cycle", 64'(fc), 64'(N + 3));
    chk("busy_cycles", 64'(busy_cnt), 64'(N + 3));
    chk("beats_full_rate", 64'(beat_idx), 64'(N));
    start = 1'b1;                       // start coincident with frame_done
    step();
    start = 1'b0;
    chk("done_pulse_count", 64'(done_cnt), 64'd1);
    chk("start_at_done_ignored", 64'({busy, mem_rd_en, frame_done}), 64'd0);
    step();
    chk("still_idle", 64'({busy, mem_rd_en, out_valid}), 64'd0);

    // Toggling ready 1,0,0,1
    mode = 1;
    begin_frame();
    wait_done(-1);
    step();
    chk("beats_toggle", 64'(beat_idx), 64'(N));
    chk("done_toggle", 64'(done_cnt), 64'd1);

    // Ready held low for 20 cycles after start
    fill_random();
    mode = 2; out_ready = 1'b0;
    begin_frame();
    repeat (19) begin step(); fc++; end
    chk("stall_reads", 64'(issue_idx), 64'd2);
    chk("stall_head", 64'({out_valid, out_pixel}), 64'({1'b1, exp_pix[0]}));
    mode = 0;
    wait_done(-1);
    step();
    chk("beats_after_stall", 64'(beat_idx), 64'(N));
    chk("reads_after_stall", 64'(issue_idx), 64'(N));

    // Second start during the stream is ignored
    fill_random();
    mode = 0;
    begin_frame();
    wait_done(5);
    step();
    step();
    chk("beats_dup_start", 64'(beat_idx), 64'(N));
    chk("done_dup_start", 64'(done_cnt), 64'd1);
    chk("idle_after_dup", 64'(busy), 64'd0);
    fill_random();
    mode = 3;
    begin_frame();
    wait_done(-1);
    step();
    chk("beats_replay", 64'(beat_idx), 64'(N));

    // Reset at beat 3
    fill_random();
    mode = 0;
    begin_frame();
    repeat (5) begin step(); fc++; end
    chk("beat3_present", 64'({out_valid, out_pixel}), 64'({1'b1, exp_pix[3]}));
    rst = 1'b1;
    step();
    chk("post_rst_outputs", 64'({out_valid, busy, mem_rd_en, frame_done, out_sol, out_eol, out_eof, out_pixel, mem_addr}), 64'd0);
    rst = 1'b0;
    step();
    step();
    chk("post_rst_idle", 64'({out_valid, busy, mem_rd_en}), 64'd0);
    fill_random();
    mode = 3;
    begin_frame();
    wait_done(-1);
    step();
    chk("beats_after_rst", 64'(beat_idx), 64'(N));

    // Randomized frames with random backpressure
    for (int f = 0; f < 6; f++) begin
      fill_random();
      mode = 3;
      begin_frame();
      wait_done(-1);
      step();
      chk("beats_random", 64'(beat_idx), 64'(N));
      chk("done_random", 64'(done_cnt), 64'd1);
      repeat (f % 3) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
